dm9316_down: RTL and testbench

- Synchronous 4-bit binary down counter with parallel load, two count enables, an active-low asynchronous clear, and a borrow (terminal-count) output.
- It is the count-down counterpart of the existing 9316-style up counter in the TTL-level Pong recreation.
- Used for timers and position counters that preload a value and decrement to zero.
- Instances cascade: borrow of the low stage drives en_t of the next stage.

---
 rtl/dm9316_down_pkg.sv | 12 +
 rtl/dm9316_down_jkff.sv | 39 +++
 rtl/dm9316_down.sv | 79 +++++++
 tb/tb_dm9316_down.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dm9316_down_pkg.sv
// Constants private to the dm9316_down counter: stage width and the
// terminal-count value that borrow detects.
package dm9316_down_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  // Count value at which the stage asserts borrow (when en_t is high).
  localparam cnt_t TC_VALUE = '0;

endpackage

// File: rtl/dm9316_down_jkff.sv
// png_jkff: JK flip-flop with asynchronous active-low clear and preset,
// triggered on the falling edge of its clock input. Clear dominates preset.
module png_jkff (
  input  logic clk_i,
  input  logic clr_n_i,
  input  logic pre_n_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // JK next-state: hold, reset, set or toggle.
  always_comb begin
    q_d = q_q;
    case ({j_i, k_i})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      default: q_d = ~q_q;
    endcase
  end

  // State register; asynchronous clear wins over asynchronous preset.
  always_ff @(negedge clk_i or negedge clr_n_i or negedge pre_n_i) begin
    if (!clr_n_i) begin
      q_q <= 1'b0;
    end else if (!pre_n_i) begin
      q_q <= 1'b1;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/dm9316_down.sv
// dm9316_down: 4-bit synchronous binary down counter with parallel load,
// P/T count enables, asynchronous active-low clear and a borrow output.
// Built from gates around four JK stages, mirroring the 9316 up counter.
module dm9316_down
  import dm9316_down_pkg::*;
(
  input  logic clk,
  input  logic _clr,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic _load,
  input  logic en_p,
  input  logic en_t,
  output logic qa,
  output logic qb,
  output logic qc,
  output logic qd,
  output logic borrow
);

  // JK stages fire on the falling edge, so feeding them the inverted clock
  // moves every state change onto the rising edge of clk.
  logic clk_n;
  assign clk_n = ~clk;

  // Input inverters.
  logic ld;
  logic en_p_n;
  logic en_t_n;
  assign ld     = ~_load;
  assign en_p_n = ~en_p;
  assign en_t_n = ~en_t;

  // Internal count enable: both P and T must be high.
  logic cnt;
  assign cnt = ~(en_p_n | en_t_n);

  cnt_t din;
  cnt_t q;
  cnt_t tog;
  cnt_t j;
  cnt_t k;

  assign din = {d, c, b, a};

  // Decrement borrow chain: a bit toggles when counting and every lower
  // bit is already zero.
  assign tog[0] = cnt;
  assign tog[1] = cnt & ~q[0];
  assign tog[2] = cnt & ~q[0] & ~q[1];
  assign tog[3] = cnt & ~q[0] & ~q[1] & ~q[2];

  // Per-bit AND-OR steering: load path forces J/K to the data value,
  // otherwise J=K=toggle. Load therefore overrides counting.
  for (genvar i = 0; i < CNT_W; i++) begin : g_stage
    assign j[i] = (ld & din[i])  | (~ld & tog[i]);
    assign k[i] = (ld & ~din[i]) | (~ld & tog[i]);

    png_jkff u_ff (
      .clk_i   (clk_n),
      .clr_n_i (_clr),
      .pre_n_i (1'b1),
      .j_i     (j[i]),
      .k_i     (k[i]),
      .q_o     (q[i])
    );
  end

  assign qa = q[0];
  assign qb = q[1];
  assign qc = q[2];
  assign qd = q[3];

  // Five-input NOR: borrow high only at the terminal count with en_t high.
  assign borrow = ~((|(q ^ TC_VALUE)) | en_t_n);

endmodule

// File: tb/tb_dm9316_down.sv
// Bench for dm9316_down: directed stimulus pushes expected {borrow,Q} into a
// scoreboard queue; a monitor pops and compares on each falling clk edge.
module tb_dm9316_down;

  logic clk;
  logic clr_n;
  logic load_n;
  logic en_p;
  logic en_t;
  logic [3:0] din;
  logic qa, qb, qc, qd, bor;

  // cascade pair
  logic cas_en_t;
  logic [3:0] lo_din, hi_din;
  logic lo_qa, lo_qb, lo_qc, lo_qd, lo_bor;
  logic hi_qa, hi_qb, hi_qc, hi_qd, hi_bor;

  typedef struct {
    string      name;
    bit         cas;
    logic [8:0] want;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  dm9316_down u_dut (
    .clk(clk), ._clr(clr_n),
    .a(din[0]), .b(din[1]), .c(din[2]), .d(din[3]),
    ._load(load_n), .en_p(en_p), .en_t(en_t),
    .qa(qa), .qb(qb), .qc(qc), .qd(qd), .borrow(bor)
  );

  dm9316_down u_lo (
    .clk(clk), ._clr(clr_n),
    .a(lo_din[0]), .b(lo_din[1]), .c(lo_din[2]), .d(lo_din[3]),
    ._load(load_n), .en_p(en_p), .en_t(cas_en_t),
    .qa(lo_qa), .qb(lo_qb), .qc(lo_qc), .qd(lo_qd), .borrow(lo_bor)
  );

  dm9316_down u_hi (
    .clk(clk), ._clr(clr_n),
    .a(hi_din[0]), .b(hi_din[1]), .c(hi_din[2]), .d(hi_din[3]),
    ._load(load_n), .en_p(en_p), .en_t(lo_bor),
    .qa(hi_qa), .qb(hi_qb), .qc(hi_qc), .qd(hi_qd), .borrow(hi_bor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every pending expectation at the falling edge.
  initial begin
    exp_t e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.cas)
          got = {hi_bor, hi_qd, hi_qc, hi_qb, hi_qa, lo_qd, lo_qc, lo_qb, lo_qa};
        else
          got = {4'b0000, bor, qd, qc, qb, qa};
        total++;
        if (got !== e.want) begin
          bad++;
          $display("FAIL %s: got %b, want %b", e.name, got, e.want);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic ld_n, input logic [3:0] v,
                        input logic ep, input logic et);
    load_n = ld_n;
    din    = v;
    en_p   = ep;
    en_t   = et;
  endtask

  // One rising edge, then expect {borrow,Q} of the single counter.
  task automatic tick(input string nm, input logic bw, input logic [3:0] qv);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = nm; e.cas = 1'b0; e.want = {4'b0000, bw, qv};
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // One rising edge, then expect {pair borrow, 8-bit value} of the cascade.
  task automatic tick_cas(input string nm, input logic bw, input logic [7:0] qv);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = nm; e.cas = 1'b1; e.want = {bw, qv};
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    clr_n    = 1'b0;
    cas_en_t = 1'b0;
    lo_din   = 4'd0;
    hi_din   = 4'd0;
    set_in(1'b1, 4'b0000, 1'b1, 1'b1);

    // 1: clear, then free-running decrement from 0000
    tick("clr_hold", 1'b1, 4'b0000);
    tick("clr_hold_ld", 1'b1, 4'b0000);
    clr_n = 1'b1;
    tick("wrap_0_to_F", 1'b0, 4'b1111);
    tick("dec_E", 1'b0, 4'b1110);
    tick("dec_D", 1'b0, 4'b1101);

    // 2: load 1010, count down ten edges to zero, then wrap
    set_in(1'b0, 4'b1010, 1'b0, 1'b0);
    tick("load_A", 1'b0, 4'b1010);
    set_in(1'b1, 4'b0000, 1'b1, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      logic [3:0] v;
      v = 4'(10 - i);
      tick($sformatf("cnt_from_A_%0d", i), (v == 4'd0), v);
    end
    tick("wrap_after_A", 1'b0, 4'b1111);

    // 3: enable gating
    set_in(1'b0, 4'b0101, 1'b0, 1'b0);
    tick("load_5", 1'b0, 4'b0101);
    set_in(1'b1, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick($sformatf("hold_enp0_%0d", i), 1'b0, 4'b0101);
    set_in(1'b0, 4'b0000, 1'b0, 1'b0);
    tick("load_0_ent0", 1'b0, 4'b0000);
    set_in(1'b1, 4'b0000, 1'b1, 1'b0);
    tick("hold_ent0_zero", 1'b0, 4'b0000);
    set_in(1'b1, 4'b0000, 1'b0, 1'b1);
    tick("borrow_enp0", 1'b1, 4'b0000);
    set_in(1'b1, 4'b0000, 1'b1, 1'b1);
    tick("wrap_gate", 1'b0, 4'b1111);

    // 4: load overrides counting
    set_in(1'b0, 4'b0011, 1'b1, 1'b1);
    tick("load_pri_3", 1'b0, 4'b0011);
    set_in(1'b1, 4'b0000, 1'b1, 1'b1);
    tick("dec_after_load", 1'b0, 4'b0010);

    // 5: asynchronous clear between edges, then held across a load edge
    set_in(1'b0, 4'b1001, 1'b0, 1'b0);
    tick("load_9", 1'b0, 4'b1001);
    set_in(1'b1, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    clr_n = 1'b0;
    #1;
    clr_n = 1'b1;
    e.name = "async_clr"; e.cas = 1'b0; e.want = {4'b0000, 1'b0, 4'b0000};
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    set_in(1'b0, 4'b1001, 1'b0, 1'b0);
    tick("reload_9", 1'b0, 4'b1001);
    clr_n = 1'b0;
    set_in(1'b0, 4'b1111, 1'b1, 1'b1);
    tick("clr_over_load", 1'b1, 4'b0000);
    clr_n = 1'b1;

    // 6: cascaded pair loaded with 0x01
    lo_din   = 4'h1;
    hi_din   = 4'h0;
    cas_en_t = 1'b1;
    set_in(1'b0, 4'b0000, 1'b1, 1'b1);
    tick_cas("cas_load_01", 1'b0, 8'h01);
    set_in(1'b1, 4'b0000, 1'b1, 1'b1);
    tick_cas("cas_00", 1'b1, 8'h00);
    tick_cas("cas_FF", 1'b0, 8'hFF);
    for (int i = 1; i <= 255; i++) begin
      logic [7:0] v;
      v = 8'(255 - i);
      tick_cas($sformatf("cas_dec_%0d", i), (v == 8'h00), v);
    end

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
